// File: rtl/onchip_mem_editor_master.sv
// Command-driven read / write / fill master for a single-port on-chip RAM with one-cycle read latency.
// Optional feature: define MEM_EDITOR_VERIFY_EN to read back and compare every written word.
module onchip_mem_editor_master #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32000,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [3:0]        avm_byteenable,
    output logic              avm_clken,
    input  logic [DATA_W-1:0] avm_readdata
);

    localparam int SUM_W = ADDR_W + LEN_W + 1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_ISSUE  = 4'd1,
        RD_WAIT   = 4'd2,
        RD_HOLD   = 4'd3,
        WR_DATA   = 4'd4,
        FILL      = 4'd5,
`ifdef MEM_EDITOR_VERIFY_EN
        VFY_ISSUE = 4'd6,
        VFY_CHECK = 4'd7,
`endif
        DONE      = 4'd8
    } state_t;

    // The end address is formed one bit wider than both operands so it can never wrap.
    function automatic logic range_bad(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        logic [SUM_W-1:0] end_v;
        end_v = SUM_W'(a) + SUM_W'(l);
        return (end_v > SUM_W'(DEPTH));
    endfunction

    state_t            state_r, state_nx_s;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  remain_r;
    logic [DATA_W-1:0] fill_data_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              err_r;
`ifdef MEM_EDITOR_VERIFY_EN
    logic [DATA_W-1:0] wdata_r;
    logic              fill_mode_r;
`endif
    logic              cmd_ready_s, accept_s, cmd_bad_s, last_s, wr_fire_s;
    logic              cs_s, we_s;
    logic [DATA_W-1:0] wdata_s;

    assign cmd_ready_s = reset_n & (state_r == IDLE);
    assign accept_s    = cmd_valid & cmd_ready_s;
    assign cmd_bad_s   = (cmd_op == 2'b11) | range_bad(cmd_addr, cmd_len);
    assign last_s      = (remain_r == LEN_W'(1));
    assign wr_fire_s   = reset_n & (state_r == WR_DATA) & wr_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_nx_s = IDLE;
                end else if (cmd_bad_s || (cmd_len == LEN_W'(0))) begin
                    state_nx_s = DONE;
                end else if (cmd_op == 2'b00) begin
                    state_nx_s = RD_ISSUE;
                end else if (cmd_op == 2'b01) begin
                    state_nx_s = WR_DATA;
                end else begin
                    state_nx_s = FILL;
                end
            end
            RD_ISSUE: state_nx_s = RD_WAIT;
            RD_WAIT:  state_nx_s = RD_HOLD;
            RD_HOLD: begin
                if (!rd_ready) begin
                    state_nx_s = RD_HOLD;
                end else if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RD_ISSUE;
                end
            end
`ifdef MEM_EDITOR_VERIFY_EN
            WR_DATA: begin
                if (wr_fire_s) begin
                    state_nx_s = VFY_ISSUE;
                end else begin
                    state_nx_s = WR_DATA;
                end
            end
            FILL:      state_nx_s = VFY_ISSUE;
            VFY_ISSUE: state_nx_s = VFY_CHECK;
            VFY_CHECK: begin
                if (remain_r == LEN_W'(0)) begin
                    state_nx_s = DONE;
                end else if (fill_mode_r) begin
                    state_nx_s = FILL;
                end else begin
                    state_nx_s = WR_DATA;
                end
            end
`else
            WR_DATA: begin
                if (wr_fire_s && last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = WR_DATA;
                end
            end
            FILL: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = FILL;
                end
            end
`endif
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Address, length, data capture and sticky error
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_r      <= ADDR_W'(0);
            remain_r    <= LEN_W'(0);
            fill_data_r <= DATA_W'(0);
            rd_data_r   <= DATA_W'(0);
            err_r       <= 1'b0;
`ifdef MEM_EDITOR_VERIFY_EN
            wdata_r     <= DATA_W'(0);
            fill_mode_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r      <= cmd_addr;
                        remain_r    <= cmd_len;
                        fill_data_r <= cmd_data;
                        err_r       <= cmd_bad_s;
`ifdef MEM_EDITOR_VERIFY_EN
                        fill_mode_r <= (cmd_op == 2'b10);
`endif
                    end
                end
                RD_WAIT: rd_data_r <= avm_readdata;
                RD_HOLD: begin
                    if (rd_ready) begin
                        remain_r <= remain_r - LEN_W'(1);
                        if (!last_s) addr_r <= addr_r + ADDR_W'(1);
                    end
                end
`ifdef MEM_EDITOR_VERIFY_EN
                WR_DATA: begin
                    if (wr_fire_s) begin
                        remain_r <= remain_r - LEN_W'(1);
                        wdata_r  <= wr_data;
                    end
                end
                FILL: begin
                    remain_r <= remain_r - LEN_W'(1);
                    wdata_r  <= fill_data_r;
                end
                // A miscompare is recorded but never stops the transfer.
                VFY_CHECK: begin
                    if (avm_readdata != wdata_r) err_r <= 1'b1;
                    if (remain_r != LEN_W'(0)) addr_r <= addr_r + ADDR_W'(1);
                end
`else
                WR_DATA: begin
                    if (wr_fire_s) begin
                        remain_r <= remain_r - LEN_W'(1);
                        if (!last_s) addr_r <= addr_r + ADDR_W'(1);
                    end
                end
                FILL: begin
                    remain_r <= remain_r - LEN_W'(1);
                    if (!last_s) addr_r <= addr_r + ADDR_W'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    // Bus strobes decoded from state; write data comes straight from the stream on a handshake
    always_comb begin
        cs_s    = 1'b0;
        we_s    = 1'b0;
        wdata_s = fill_data_r;
        case (state_r)
            RD_ISSUE: cs_s = 1'b1;
            WR_DATA: begin
                if (wr_fire_s) begin
                    cs_s    = 1'b1;
                    we_s    = 1'b1;
                    wdata_s = wr_data;
                end else begin
                    cs_s    = 1'b0;
                    we_s    = 1'b0;
                end
            end
            FILL: begin
                cs_s = 1'b1;
                we_s = 1'b1;
            end
`ifdef MEM_EDITOR_VERIFY_EN
            VFY_ISSUE: cs_s = 1'b1;
`endif
            default: begin
                cs_s = 1'b0;
                we_s = 1'b0;
            end
        endcase
    end

    // Reset gates the strobes so an abort cannot leak one more access.
    assign avm_chipselect = cs_s & reset_n;
    assign avm_write      = we_s & reset_n;
    assign avm_writedata  = wdata_s;
    assign avm_address    = addr_r;
    assign avm_byteenable = 4'hF;
    assign avm_clken      = 1'b1;
    assign cmd_ready      = cmd_ready_s;
    assign wr_ready       = reset_n & (state_r == WR_DATA);
    assign rd_valid       = (state_r == RD_HOLD);
    assign rd_data        = rd_data_r;
    assign busy           = (state_r != IDLE);
    assign done           = (state_r == DONE);
    assign err            = err_r;

endmodule

// File: tb/tb_onchip_mem_editor_master.sv
// Self-checking bench for onchip_mem_editor_master: RAM slave, command-level scoreboard, directed vectors.
`timescale 1ns/1ps
module tb_onchip_mem_editor_master;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32000;
    localparam int LEN_W  = 16;
`ifdef MEM_EDITOR_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0, cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              wr_valid = 1'b0, wr_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_valid, rd_ready = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              busy, done, err;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect, avm_write, avm_clken;
    logic [DATA_W-1:0] avm_writedata, avm_readdata;
    logic [3:0]        avm_byteenable;

    always #5 clk = ~clk;

    onchip_mem_editor_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable), .avm_clken(avm_clken),
        .avm_readdata(avm_readdata)
    );

    // RAM slave (one-cycle read latency) and the model's idea of what the RAM should hold
    logic [31:0] ram     [0:32767];
    logic [31:0] ref_mem [0:32767];
    int          corrupt_addr = -1;

    always @(posedge clk) begin
        if (avm_chipselect === 1'b1) begin
            if (avm_write === 1'b1)
                ram[avm_address] <= (int'(avm_address) == corrupt_addr) ? (avm_writedata ^ 32'h1) : avm_writedata;
            else
                avm_readdata <= ram[avm_address];
        end
    end

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int exp_wa_q[$];
    logic [31:0] exp_wd_q[$], exp_rd_q[$], got_rd_q[$];
    int wr_cyc_q[$];
    int lo = 1, hi = 0, wr_cnt = 0, done_cnt = 0, wr_addr_m = 0;
    logic exp_err_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the scoreboard, sampled on the falling edge
    int          a_m;
    logic        prev_rv = 1'b0, prev_rr = 1'b0, prev_done = 1'b0, prev_rst = 1'b0;
    logic [31:0] prev_rd = '0, pop_v;
    initial forever begin
        @(negedge clk);
        if (reset_n !== 1'b1) begin
            check("reset_chipselect", avm_chipselect, 0);
            check("reset_write", avm_write, 0);
            check("reset_cmd_ready", cmd_ready, 0);
        end else begin
            check("rd_wr_exclusive", rd_valid & wr_ready, 0);
            if (avm_chipselect === 1'b1) begin
                a_m = int'(avm_address);
                check("addr_in_range", (a_m >= lo) && (a_m <= hi), 1);
                if (avm_write === 1'b1) begin
                    wr_cnt++;
                    wr_cyc_q.push_back(cyc);
                    check("write_expected", exp_wa_q.size() != 0, 1);
                    if (exp_wa_q.size() != 0) begin
                        check("write_addr", avm_address, exp_wa_q.pop_front());
                        check("write_data", avm_writedata, exp_wd_q.pop_front());
                    end
                end
            end
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                check("read_expected", exp_rd_q.size() != 0, 1);
                got_rd_q.push_back(rd_data);
                if (exp_rd_q.size() != 0) begin
                    pop_v = exp_rd_q.pop_front();
                    check("read_data", rd_data, pop_v);
                end
            end
            if (prev_rst && prev_rv && !prev_rr) begin
                check("rd_valid_held", rd_valid, 1);
                check("rd_data_held", rd_data, prev_rd);
            end
            if (done === 1'b1) begin
                done_cnt++;
                check("done_single_cycle", prev_done, 0);
            end
        end
        prev_rv = rd_valid; prev_rr = rd_ready; prev_rd = rd_data;
        prev_done = done; prev_rst = reset_n;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Model the whole command up front: legality, address window, fill writes and read results
    task automatic start_cmd(input logic [1:0] op, input int addr, input int len, input logic [31:0] data);
        int  n = 0;
        bit  bad;
        exp_wa_q.delete(); exp_wd_q.delete(); exp_rd_q.delete(); got_rd_q.delete(); wr_cyc_q.delete();
        wr_cnt = 0;
        bad = (op == 2'b11) || (addr + len > DEPTH);
        exp_err_m = bad;
        wr_addr_m = addr;
        if (bad || len == 0) begin lo = 1; hi = 0; end
        else begin lo = addr; hi = addr + len - 1; end
        if (!bad) begin
            for (int i = 0; i < len; i++) begin
                if (op == 2'b10) begin
                    exp_wa_q.push_back(addr + i); exp_wd_q.push_back(data);
                    ref_mem[addr + i] = data;
                    if (VFY && (addr + i == corrupt_addr)) exp_err_m = 1'b1;
                end else if (op == 2'b00) begin
                    exp_rd_q.push_back(ref_mem[addr + i]);
                end
            end
        end
        while (cmd_ready !== 1'b1 && n < 50) begin step(); n++; end
        check("cmd_ready_in_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr[ADDR_W-1:0]; cmd_len = len[LEN_W-1:0]; cmd_data = data;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [31:0] d, input int gap);
        int n = 0;
        exp_wa_q.push_back(wr_addr_m); exp_wd_q.push_back(d);
        ref_mem[wr_addr_m] = d;
        if (VFY && (wr_addr_m == corrupt_addr)) exp_err_m = 1'b1;
        wr_addr_m++;
        wr_valid = 1'b1; wr_data = d;
        while (wr_ready !== 1'b1 && n < 50) begin step(); n++; end
        check("wr_ready_seen", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic take_word(input int hold);
        int n = 0;
        while (rd_valid !== 1'b1 && n < 50) begin step(); n++; end
        check("rd_valid_seen", rd_valid, 1);
        repeat (hold) step();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input int exp_lat);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin step(); n++; end
        $display("%s: done after %0d cycles", name, n);
        check("done_seen", done, 1);
        if (exp_lat >= 0) check("done_latency", n, exp_lat);
        check("err_at_done", err, exp_err_m);
        check("writes_outstanding", exp_wa_q.size(), 0);
        check("reads_outstanding", exp_rd_q.size(), 0);
        step();
        check("done_dropped", done, 0);
        check("idle_not_busy", busy, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("err_sticky", err, exp_err_m);
    endtask

    int done0;
    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i] = 32'hDEAD0000 | i;
            ref_mem[i] = 32'hDEAD0000 | i;
        end
        repeat (2) step();
        check("rst_busy", busy, 0);   check("rst_done", done, 0);   check("rst_err", err, 0);
        check("rst_rd_valid", rd_valid, 0); check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_data", rd_data, 0);   check("rst_address", avm_address, 0);
        check("rst_cmd_ready_low", cmd_ready, 0);
        check("byteenable", avm_byteenable, 4'hF); check("clken", avm_clken, 1);
        reset_n = 1'b1;
        step();
        check("cmd_ready_after_reset", cmd_ready, 1);

        // fill 0x10..0x13 back-to-back
        start_cmd(2'b10, 32'h10, 4, 32'hA5A5A5A5);
        wait_done("fill4", 60, -1);
        check("fill4_count", wr_cyc_q.size(), 4);
        if (wr_cyc_q.size() == 4) check("fill4_span", wr_cyc_q[3] - wr_cyc_q[0], VFY ? 9 : 3);
        check("fill4_ram_lo", ram[16'h10], 32'hA5A5A5A5);
        check("fill4_ram_hi", ram[16'h13], 32'hA5A5A5A5);
        check("fill4_ram_past", ram[16'h14], 32'hDEAD0014);

        // streamed write with a 3-cycle gap, then read back with a 5-cycle stall
        start_cmd(2'b01, 32'h7CFE, 2, 32'h0);
        feed_word(32'h11111111, 3);
        feed_word(32'h22222222, 0);
        wait_done("write2", 60, -1);
        check("write2_count", wr_cnt, 2);
        check("write2_ram0", ram[16'h7CFE], 32'h11111111);
        check("write2_ram1", ram[16'h7CFF], 32'h22222222);

        start_cmd(2'b00, 32'h7CFE, 2, 32'h0);
        take_word(5);
        take_word(0);
        wait_done("read2", 60, -1);
        check("read2_count", got_rd_q.size(), 2);
        if (got_rd_q.size() == 2) begin
            check("read2_word0", got_rd_q[0], 32'h11111111);
            check("read2_word1", got_rd_q[1], 32'h22222222);
        end

        // out-of-range, zero length, reserved opcode
        start_cmd(2'b00, 31999, 2, 32'h0);
        wait_done("read_oob", 10, 0);
        check("oob_model_err", exp_err_m, 1);
        start_cmd(2'b10, 100, 0, 32'h12345678);
        wait_done("fill_len0", 10, 0);
        start_cmd(2'b11, 0, 1, 32'h0);
        wait_done("op_reserved", 10, 0);

        // last legal words of the memory; err must clear on accept
        start_cmd(2'b10, 31998, 2, 32'hC3C30F0F);
        check("err_cleared_on_accept", err, 0);
        wait_done("fill_top", 30, -1);
        start_cmd(2'b00, 31999, 1, 32'h0);
        take_word(0);
        wait_done("read_top", 30, -1);
        if (got_rd_q.size() == 1) check("read_top_word", got_rd_q[0], 32'hC3C30F0F);
        else check("read_top_count", got_rd_q.size(), 1);

        // reset in the middle of a long fill
        start_cmd(2'b10, 32'h200, 100, 32'h5A5A0000);
        for (int n = 0; n < 400 && wr_cnt < 40; n++) step();
        reset_n = 1'b0;
        exp_wa_q.delete(); exp_wd_q.delete(); lo = 1; hi = 0;
        done0 = done_cnt;
        check("abort_write_count", wr_cnt, 40);
        step();
        check("abort_chipselect", avm_chipselect, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        step();
        reset_n = 1'b1;
        step();
        check("abort_cmd_ready", cmd_ready, 1);
        repeat (5) step();
        check("abort_no_done", done_cnt, done0);
        check("abort_last_word", ram[16'h227], 32'h5A5A0000);
        check("abort_untouched", ram[16'h228], 32'hDEAD0228);

        // RAM flips bit 0 at address 5: only the read-back build may flag it
        corrupt_addr = 5;
        start_cmd(2'b10, 4, 3, 32'h0F0F1234);
        wait_done("fill_corrupt", 60, -1);
        check("corrupt_count", wr_cyc_q.size(), 3);
        check("corrupt_ram", ram[5], 32'h0F0F1235);
`ifdef MEM_EDITOR_VERIFY_EN
        check("corrupt_model_err", exp_err_m, 1);
        if (wr_cyc_q.size() == 3) check("corrupt_span", wr_cyc_q[2] - wr_cyc_q[0], 6);
`else
        check("corrupt_model_err", exp_err_m, 0);
        if (wr_cyc_q.size() == 3) check("corrupt_span", wr_cyc_q[2] - wr_cyc_q[0], 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/onchip_mem_editor_master.md
ONCHIP_MEM_EDITOR_MASTER -- requirements
Module: onchip_mem_editor_master

Interface
REQ-001 SHALL have parameters: ADDR_W, default 15, word address width; DATA_W, default 32, data width; DEPTH, default 32000, memory depth in words; LEN_W, default 16, transfer length width.
REQ-002 SHALL have port clk, input, 1, single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have cmd_valid input 1, cmd_ready output 1, cmd_op input 2 (00 read, 01 write, 10 fill, 11 reserved), cmd_addr input ADDR_W, cmd_len input LEN_W (words), cmd_data input DATA_W (fill pattern).
REQ-005 SHALL have wr_valid input 1, wr_ready output 1, wr_data input DATA_W: write-data stream.
REQ-006 SHALL have rd_valid output 1, rd_ready input 1, rd_data output DATA_W: read-data stream.
REQ-007 SHALL have busy output 1, done output 1 (one-cycle pulse), err output 1 (sticky until next accepted command).
REQ-008 SHALL have memory-side ports: avm_address output ADDR_W, avm_chipselect output 1, avm_write output 1, avm_writedata output DATA_W, avm_byteenable output 4 (tied 4'hF), avm_clken output 1 (tied 1), avm_readdata input DATA_W.

Function
REQ-009 SHALL accept a command when cmd_valid & cmd_ready; cmd_ready = 1 only in IDLE.
REQ-010 SHALL use states IDLE, RD_ISSUE, RD_WAIT, RD_HOLD, WR_DATA, FILL, VFY_ISSUE, VFY_CHECK, DONE.
REQ-011 SHALL, on accept, go to DONE with err=1 and no bus access if cmd_op=11 or cmd_addr+cmd_len > DEPTH (sum computed at ADDR_W+LEN_W+1 bits, no wrap).
REQ-012 SHALL, on accept with cmd_len=0 and valid op, go to DONE with err=0 and no bus access.
REQ-013 Read: RD_ISSUE drives chipselect=1, write=0, address=current for one cycle; RD_WAIT captures avm_readdata the next cycle into rd_data, rd_valid=1; RD_HOLD holds rd_data stable until rd_ready; then address+1 and RD_ISSUE, or DONE after last word.
REQ-014 Write: in WR_DATA wr_ready=1; on wr_valid&wr_ready SHALL drive chipselect=1, write=1, writedata=wr_data in the same cycle, then advance address; at most one write per cycle.
REQ-015 Fill: SHALL write cmd_data to consecutive addresses, one word per cycle, no stream handshake.
REQ-016 SHALL drive avm_chipselect=0, avm_write=0 in all states not listed as issuing.
REQ-017 done SHALL pulse for exactly one cycle in DONE, then return to IDLE; busy=1 in every state except IDLE.
REQ-018 rd_valid and wr_ready SHALL never be 1 simultaneously; rd_valid SHALL not drop without rd_ready.
REQ-019 Address SHALL never exceed cmd_addr+cmd_len-1; remaining-word counter SHALL be LEN_W bits.

Reset
REQ-020 On clk edge with reset_n=0, SHALL enter IDLE; cmd_ready=0 during reset cycle then 1; busy, done, err, rd_valid, wr_ready, avm_chipselect, avm_write = 0; rd_data, avm_address = 0.
REQ-021 Reset mid-transfer SHALL abort immediately with no further bus access and no done pulse.

Configuration
REQ-022 With MEM_EDITOR_VERIFY_EN defined, each write/fill word SHALL be followed by VFY_ISSUE (read same address) and VFY_CHECK (compare avm_readdata to written value); mismatch sets err=1, transfer continues; write throughput becomes 1 word per 3 cycles.
REQ-023 Without MEM_EDITOR_VERIFY_EN, VFY states SHALL not exist and writes proceed back-to-back.

Verification
REQ-024 Fill addr=0x0010 len=4 data=0xA5A5A5A5 -> writes at 0x10..0x13 on 4 consecutive cycles, done pulse, err=0.
REQ-025 Write addr=0x7CFE len=2, stream 0x11111111,0x22222222 with wr_valid gap of 3 cycles -> writes only on handshake cycles; then read addr=0x7CFE len=2 with rd_ready low 5 cycles -> rd_data held, returns 0x11111111 then 0x22222222.
REQ-026 Read addr=31999 len=2 -> err=1, done pulse 1 cycle after accept, chipselect never asserted.
REQ-027 Fill len=0 -> done, err=0, no bus access; cmd_op=11 -> done, err=1.
REQ-028 Assert reset_n=0 during fill of len=100 at word 40 -> chipselect=0 next cycle, no done, cmd_ready=1 after release.
REQ-029 With MEM_EDITOR_VERIFY_EN, memory model corrupting bit 0 at addr 5, fill addr=4 len=3 -> err=1 at done, all 3 words written.
